fetch_unit: RTL and testbench

Instruction fetch stage of the 4-bit CPU. It holds the program counter and fetches 8-bit instruction words from instruction memory over a req/ack handshake. It latches each word into an instruction register and presents the opcode and immediate to the control unit for exactly one execute cycle. It consumes the control unit's jump-select decision to choose the next PC: either the immediate target or PC+1.

---
 rtl/fetch_unit.sv | 113 +++++++++++
 tb/tb_fetch_unit.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch stage: PC, IR and req/ack fetch FSM
module fetch_unit #(
    parameter int PC_W    = 4,
    parameter int INSTR_W = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               hold,
    output logic               imem_req,
    output logic [PC_W-1:0]    imem_addr,
    input  logic               imem_ack,
    input  logic [INSTR_W-1:0] imem_rdata,
    input  logic               jmp_sel,
    output logic [3:0]         opcode,
    output logic [3:0]         imm,
    output logic               exec_valid,
    output logic [PC_W-1:0]    pc
);

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_WAIT  = 2'd1,
        S_EXEC  = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [PC_W-1:0]      pc_q, pc_d;
    logic [INSTR_W-1:0]   ir_q, ir_d;
    logic                 imem_req_q, imem_req_d;
    logic                 exec_valid_q, exec_valid_d;

    logic [PC_W-1:0]      jump_target;
    logic [PC_W-1:0]      pc_inc;

    // The immediate is 4 bits; fit it to the PC width (zero-extend or truncate)
    generate
        if (PC_W > 4) begin : g_tgt_ext
            assign jump_target = {{(PC_W-4){1'b0}}, ir_q[3:0]};
        end else if (PC_W == 4) begin : g_tgt_eq
            assign jump_target = ir_q[3:0];
        end else begin : g_tgt_trunc
            assign jump_target = ir_q[PC_W-1:0];
        end
    endgenerate

    // Sequential PC wraps naturally at 2^PC_W
    assign pc_inc = pc_q + PC_W'(1);

    // Next-state logic: fetch request, IR capture on ack, PC update in EXEC
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        ir_d         = ir_q;
        imem_req_d   = imem_req_q;
        exec_valid_d = exec_valid_q;
        case (state_q)
            S_FETCH: begin
                exec_valid_d = 1'b0;
                if (!hold) begin
                    imem_req_d = 1'b1;
                    state_d    = S_WAIT;
                end else begin
                    imem_req_d = 1'b0;
                end
            end
            S_WAIT: begin
                // hold is deliberately ignored here: a started fetch always completes
                if (imem_ack) begin
                    ir_d         = imem_rdata;
                    imem_req_d   = 1'b0;
                    exec_valid_d = 1'b1;
                    state_d      = S_EXEC;
                end
            end
            S_EXEC: begin
                pc_d         = jmp_sel ? jump_target : pc_inc;
                exec_valid_d = 1'b0;
                imem_req_d   = 1'b0;
                state_d      = S_FETCH;
            end
            default: begin
                imem_req_d   = 1'b0;
                exec_valid_d = 1'b0;
                state_d      = S_FETCH;
            end
        endcase
    end

    // State and output registers; reset abandons any outstanding request
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_FETCH;
            pc_q         <= '0;
            ir_q         <= '0;
            imem_req_q   <= 1'b0;
            exec_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            ir_q         <= ir_d;
            imem_req_q   <= imem_req_d;
            exec_valid_q <= exec_valid_d;
        end
    end

    assign imem_req   = imem_req_q;
    assign imem_addr  = pc_q;
    assign pc         = pc_q;
    assign opcode     = ir_q[7:4];
    assign imm        = ir_q[3:0];
    assign exec_valid = exec_valid_q;

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - scoreboard bench for fetch_unit
module tb_fetch_unit;

    logic       clk;
    logic       rst_n;
    logic       hold;
    logic       imem_req;
    logic [3:0] imem_addr;
    logic       imem_ack;
    logic [7:0] imem_rdata;
    logic       jmp_sel;
    logic [3:0] opcode;
    logic [3:0] imm;
    logic       exec_valid;
    logic [3:0] pc;

    fetch_unit #(.PC_W(4), .INSTR_W(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .hold       (hold),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ack   (imem_ack),
        .imem_rdata (imem_rdata),
        .jmp_sel    (jmp_sel),
        .opcode     (opcode),
        .imm        (imm),
        .exec_valid (exec_valid),
        .pc         (pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] op;
        logic [3:0] im;
        logic [3:0] at_pc;
        logic [3:0] next_pc;
        int         period;
    } exp_t;

    exp_t exp_q[$];

    int pass_cnt  = 0;
    int check_cnt = 0;
    int cycle     = 0;

    logic [7:0]  mem [16];
    logic [15:0] jmp_tab;
    int          wait_n;
    int          mem_cnt;
    logic        mem_ack;
    logic [7:0]  mem_rdata;
    logic        inject;

    always @(posedge clk) cycle <= cycle + 1;

    // Control-unit stand-in: jmp_sel is 1 outside EXEC to prove it is ignored there
    always_comb begin
        jmp_sel    = exec_valid ? jmp_tab[pc] : 1'b1;
        imem_ack   = mem_ack | inject;
        imem_rdata = inject ? 8'hFF : mem_rdata;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        check_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cycle);
    endtask

    task automatic push(input logic [7:0] w, input logic [3:0] p, input logic [3:0] np, input int per);
        exp_t e;
        e.op = w[7:4]; e.im = w[3:0]; e.at_pc = p; e.next_pc = np; e.period = per;
        exp_q.push_back(e);
    endtask

    task automatic wait_exec(input int n);
        int seen;
        seen = 0;
        for (int i = 0; i < 200 && seen < n; i++) begin
            @(negedge clk);
            if (exec_valid) seen++;
        end
        if (seen < n) begin
            check_cnt++;
            $display("FAIL wait_exec: got %0d pulses expected %0d", seen, n);
        end
    endtask

    // Memory model with a programmable number of wait cycles
    initial begin
        mem_cnt   = 0;
        mem_ack   = 1'b0;
        mem_rdata = 8'h00;
        forever begin
            @(negedge clk);
            if (imem_req) begin
                if (mem_cnt == wait_n) begin
                    mem_ack   = 1'b1;
                    mem_rdata = mem[imem_addr];
                end else begin
                    mem_cnt++;
                    mem_ack = 1'b0;
                end
            end else begin
                mem_cnt = 0;
                mem_ack = 1'b0;
            end
        end
    end

    // Monitor: pops one expectation per EXEC pulse
    initial begin
        exp_t e;
        int   last_exec;
        last_exec = 0;
        forever begin
            @(negedge clk);
            if (rst_n && exec_valid) begin
                if (exp_q.size() == 0) begin
                    check_cnt++;
                    $display("FAIL unexpected_exec: got pc %0h expected no instruction", pc);
                end else begin
                    e = exp_q.pop_front();
                    check("opcode", 32'(opcode), 32'(e.op));
                    check("imm", 32'(imm), 32'(e.im));
                    check("exec_pc", 32'(pc), 32'(e.at_pc));
                    if (e.period != 0) check("period", cycle - last_exec, e.period);
                    last_exec = cycle;
                    @(negedge clk);
                    check("next_pc", 32'(pc), 32'(e.next_pc));
                end
            end
        end
    end

    // Stimulus
    initial begin
        bit found;
        foreach (mem[i]) mem[i] = 8'h00;
        mem[0]  = 8'h41; mem[1]  = 8'h82; mem[2] = 8'hC3; mem[3] = 8'h10;
        mem[4]  = 8'h3A; mem[10] = 8'h2F; mem[15] = 8'h77;
        jmp_tab = 16'h0000;
        jmp_tab[4]  = 1'b1;
        jmp_tab[10] = 1'b1;
        wait_n = 0;
        inject = 1'b0;
        hold   = 1'b0;
        rst_n  = 1'b0;

        repeat (2) @(negedge clk);
        check("rst_pc", 32'(pc), 0);
        check("rst_req", 32'(imem_req), 0);
        check("rst_exec", 32'(exec_valid), 0);
        check("rst_opcode", 32'(opcode), 0);
        check("rst_imm", 32'(imm), 0);

        // Zero-wait run: sequential, two jumps, wrap at 15
        push(8'h41, 4'h0, 4'h1, 0);
        push(8'h82, 4'h1, 4'h2, 3);
        push(8'hC3, 4'h2, 4'h3, 3);
        push(8'h10, 4'h3, 4'h4, 3);
        push(8'h3A, 4'h4, 4'hA, 3);
        push(8'h2F, 4'hA, 4'hF, 3);
        push(8'h77, 4'hF, 4'h0, 3);
        rst_n = 1'b1;
        @(negedge clk);
        check("first_req", 32'(imem_req), 1);
        check("first_addr", 32'(imem_addr), 0);
        wait_exec(7);

        // Two wait cycles from here on
        wait_n = 2;
        push(8'h41, 4'h0, 4'h1, 5);
        push(8'h82, 4'h1, 4'h2, 5);
        wait_exec(1);
        @(negedge clk);
        check("fetch_state_req", 32'(imem_req), 0);
        inject = 1'b1;
        @(negedge clk);
        inject = 1'b0;
        check("stray_ack_opcode", 32'(opcode), 4);
        check("stray_ack_imm", 32'(imm), 1);
        check("wait1_req", 32'(imem_req), 1);
        check("wait1_addr", 32'(imem_addr), 1);
        @(negedge clk);
        check("wait2_req", 32'(imem_req), 1);
        check("wait2_addr", 32'(imem_addr), 1);
        hold = 1'b1;
        @(negedge clk);
        check("wait3_req", 32'(imem_req), 1);
        check("wait3_addr", 32'(imem_addr), 1);
        wait_exec(1);

        // Parked in FETCH under hold
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("park_req", 32'(imem_req), 0);
            check("park_pc", 32'(pc), 2);
            check("park_exec", 32'(exec_valid), 0);
        end
        jmp_tab[4] = 1'b0;
        push(8'hC3, 4'h2, 4'h3, 0);
        push(8'h10, 4'h3, 4'h4, 5);
        push(8'h3A, 4'h4, 4'h5, 5);
        hold = 1'b0;
        @(negedge clk);
        check("release_req", 32'(imem_req), 1);
        check("release_addr", 32'(imem_addr), 2);

        // Reset in the middle of the fetch at pc=5
        found = 1'b0;
        for (int i = 0; i < 100 && !found; i++) begin
            @(negedge clk);
            if (imem_req && imem_addr == 4'h5) found = 1'b1;
        end
        check("reach_pc5", 32'(found), 1);
        @(negedge clk);
        check("pre_rst_pc", 32'(pc), 5);
        check("pre_rst_opcode", 32'(opcode), 3);
        rst_n = 1'b0;
        #1;
        check("mid_rst_pc", 32'(pc), 0);
        check("mid_rst_req", 32'(imem_req), 0);
        check("mid_rst_exec", 32'(exec_valid), 0);
        check("mid_rst_opcode", 32'(opcode), 0);
        check("mid_rst_imm", 32'(imm), 0);
        wait_n = 0;
        repeat (2) @(negedge clk);
        push(8'h41, 4'h0, 4'h1, 0);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_req", 32'(imem_req), 1);
        check("post_rst_addr", 32'(imem_addr), 0);
        wait_exec(1);
        hold = 1'b1;
        repeat (5) @(negedge clk);
        check("queue_drained", exp_q.size(), 0);

        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule
